spi_send_arbiter: RTL and testbench
===================================

Name: spi_send_arbiter

Overview:
Packet-level round-robin arbiter that shares one spi_send AXI4-Stream byte input between NUM_SRC requesters, for example a command responder, a status reporter and a debug dump.
It sits in the axi_aclk domain directly in front of spi_send.
Once a requester is granted, it keeps the grant until its packet completes (rlast), so bytes from different packets never interleave on the SPI link.
An optional beat limit stops a requester that never asserts rlast from holding the link indefinitely.

Parameters:
NUM_SRC, 3, number of requester ports (2..8).
DATA_W, 8, stream data width; must match spi_send.
MAX_BEATS, 64, maximum beats per grant; 0 disables the limit.
ID_W, $clog2(NUM_SRC), width of grant_id.

Ports:
axi_aclk  in  1  sole clock.
axi_aresetn  in  1  synchronous, active-low reset.
s_axis_rvalid  in  NUM_SRC  per-requester valid.
s_axis_rready  out  NUM_SRC  per-requester ready.
s_axis_rdata  in  NUM_SRC*DATA_W  packed data; requester i occupies bits [i*DATA_W +: DATA_W].
s_axis_rlast  in  NUM_SRC  per-requester last.
m_axis_rvalid  out  1  valid to spi_send.
m_axis_rready  in  1  ready from spi_send.
m_axis_rdata  out  DATA_W  data to spi_send.
m_axis_rlast  out  1  last to spi_send (includes forced last).
grant_id  out  ID_W  index of the current or most recent granted requester.
busy  out  1  high while a packet is locked.
trunc_pulse  out  1  one-cycle pulse when MAX_BEATS forces a packet end.

Behaviour:
- Clock and reset
  - Single clock, axi_aclk. Reset is synchronous and active-low: sampled on the rising edge of axi_aclk while axi_aresetn=0.
  - Reset values: state=IDLE, busy=0, grant_id=0, trunc_pulse=0, beat_cnt=0, last_grant=NUM_SRC-1 (so requester 0 has priority first).
  - While in IDLE, all s_axis_rready are 0 and m_axis_rvalid is 0.
- State machine (two states)
  - IDLE: if any s_axis_rvalid bit is set, pick the first set bit searching from last_grant+1 upward, wrapping modulo NUM_SRC. Register it into grant_id, set busy=1, clear beat_cnt, go to LOCK on the next edge. If no bit is set, stay in IDLE.
  - LOCK: the datapath is combinational from the granted port g:
    - m_axis_rvalid = s_axis_rvalid[g]
    - m_axis_rdata = slice g of s_axis_rdata
    - s_axis_rready[g] = m_axis_rready; all other s_axis_rready = 0
    - m_axis_rlast = s_axis_rlast[g] OR force, where force = (MAX_BEATS != 0 AND beat_cnt == MAX_BEATS-1)
  - A beat is accepted when m_axis_rvalid and m_axis_rready are both high. Each accepted beat increments beat_cnt.
  - When a beat is accepted with m_axis_rlast=1: last_grant<=g, busy<=0, next state IDLE.
  - If that end was caused by force while s_axis_rlast[g]=0, trunc_pulse=1 for exactly one cycle. The requester's remaining bytes then arbitrate again as a new packet.
- Latency
  - A request raised in IDLE at edge t reaches m_axis_rvalid after edge t+1.
  - There is one idle bubble cycle between consecutive packets; this is accepted because SPI byte time is much longer than axi_aclk.
- Boundary conditions
  - Granted requester drops valid mid-packet: the grant is held and m_axis_rvalid=0 until it resumes. There is no timeout other than MAX_BEATS.
  - Other requesters asserting valid while LOCK is active: they are ignored, their ready stays 0, and their data is held upstream.
  - A single-beat packet (valid and last on the first beat) is legal: IDLE→LOCK→IDLE.
  - With a single requester continuously active, it is re-granted after each packet, still with the one bubble cycle.
  - Reset mid-packet: all state returns to reset values on the next edge; m_axis_rvalid and all s_axis_rready drop immediately on that edge.
  - beat_cnt saturates at MAX_BEATS-1 because force ends the packet at that count.
  - grant_id holds its value in IDLE; it updates only when a new grant is issued.

Decomposition:
- Shared package spi_pkg holds: SPI_DATA_W=8, the arbiter state enum (IDLE, LOCK), and a function rr_pick(req, last) returning the next granted index.
- One sub-module is natural: rr_priority_sel, the combinational round-robin picker with inputs req[NUM_SRC] and last[ID_W] and outputs gnt_idx and any_req. It is reusable by other shared resources.

Test Plan:
1. Reset, then requester 1 sends 0x5A with last=1 while m_axis_rready=1 → m_axis_rvalid rises one cycle after s_axis_rvalid[1]; m_axis_rdata=0x5A, m_axis_rlast=1, grant_id=1; busy returns to 0 after the accepted beat.
2. Requesters 0, 1 and 2 all hold 2-beat packets (0xA0,0xA1 / 0xB0,0xB1 / 0xC0,0xC1) → output order is A0 A1 B0 B1 C0 C1; packets never interleave; exactly one bubble cycle between packets.
3. Requester 0 sends 3 beats while requester 2 is valid throughout, and m_axis_rready toggles 1,0,1,0 → s_axis_rready[2] stays 0 until requester 0's last beat is accepted; no beat is lost or duplicated under backpressure.
4. MAX_BEATS=4, requester 1 streams 6 beats with no last → beat 4 carries m_axis_rlast=1 and trunc_pulse pulses once; beats 5 and 6 follow as a new packet after re-arbitration.
5. Assert axi_aresetn=0 during beat 2 of a 4-beat packet → next edge: busy=0, m_axis_rvalid=0, all s_axis_rready=0, grant_id=0; after release, requester 0 wins over requester 2 when both request.
6. Granted requester 2 drops valid for 5 cycles mid-packet while requester 0 is valid → grant stays on requester 2 (grant_id=2); requester 0 is served only after requester 2's last beat.

Source files
------------

// File: rtl/spi_pkg.sv
// Shared definitions for the spi_send front-end: data width, arbiter
// state encoding and the round-robin pick function.
package spi_pkg;

    localparam int SPI_DATA_W = 8;

    // Widest requester set the round-robin helper supports
    localparam int RR_MAX_SRC = 8;
    localparam int RR_IDX_W   = 3;

    typedef enum logic [0:0] {
        IDLE = 1'b0,
        LOCK = 1'b1
    } arb_state_e;

    // Returns the first set request bit searching upward from last+1,
    // wrapping modulo n. With no request set it returns last unchanged,
    // so callers qualify the result with their own any-request flag.
    function automatic logic [RR_IDX_W-1:0] rr_pick(
        input logic [RR_MAX_SRC-1:0] req,
        input logic [RR_IDX_W-1:0]   last,
        input int                    n
    );
        logic [RR_IDX_W-1:0] pick;
        logic                found;
        int                  idx;
        pick  = last;
        found = 1'b0;
        for (int k = 1; k <= RR_MAX_SRC; k++) begin
            idx = (int'(last) + k) % n;
            if ((k <= n) && !found && req[RR_IDX_W'(idx)]) begin
                pick  = RR_IDX_W'(idx);
                found = 1'b1;
            end
        end
        return pick;
    endfunction

endpackage

// File: rtl/rr_priority_sel.sv
// Combinational round-robin picker: chooses the next requester after the
// most recent winner. Reusable by any resource shared between requesters.
module rr_priority_sel
    import spi_pkg::*;
#(
    parameter int NUM_SRC = 3,
    parameter int ID_W    = $clog2(NUM_SRC)
) (
    input  logic [NUM_SRC-1:0] req,
    input  logic [ID_W-1:0]    last,
    output logic [ID_W-1:0]    gnt_idx,
    output logic               any_req
);

    logic [RR_MAX_SRC-1:0] req_ext_s;
    logic [RR_IDX_W-1:0]   last_ext_s;

    // Widen the request vector and last winner to the helper's fixed size, then pick
    always_comb begin
        req_ext_s  = RR_MAX_SRC'(req);
        last_ext_s = RR_IDX_W'(last);
        gnt_idx    = ID_W'(rr_pick(req_ext_s, last_ext_s, NUM_SRC));
        any_req    = |req;
    end

endmodule

// File: rtl/spi_send_arbiter.sv
// Packet-level round-robin arbiter sharing the spi_send byte stream between
// NUM_SRC requesters. A grant is held until the packet's last beat (or the
// beat limit) so packets never interleave on the SPI link.
module spi_send_arbiter
    import spi_pkg::*;
#(
    parameter int NUM_SRC   = 3,
    parameter int DATA_W    = SPI_DATA_W,
    parameter int MAX_BEATS = 64,
    parameter int ID_W      = $clog2(NUM_SRC)
) (
    input  logic                      axi_aclk,
    input  logic                      axi_aresetn,
    input  logic [NUM_SRC-1:0]        s_axis_rvalid,
    output logic [NUM_SRC-1:0]        s_axis_rready,
    input  logic [NUM_SRC*DATA_W-1:0] s_axis_rdata,
    input  logic [NUM_SRC-1:0]        s_axis_rlast,
    output logic                      m_axis_rvalid,
    input  logic                      m_axis_rready,
    output logic [DATA_W-1:0]         m_axis_rdata,
    output logic                      m_axis_rlast,
    output logic [ID_W-1:0]           grant_id,
    output logic                      busy,
    output logic                      trunc_pulse
);

    // Beat counter only has to reach MAX_BEATS-1; a limit of 0 means no limit
    localparam int CNT_W    = (MAX_BEATS > 1) ? $clog2(MAX_BEATS) : 1;
    localparam int CNT_LAST = (MAX_BEATS > 0) ? (MAX_BEATS - 1) : 0;
    localparam logic [ID_W-1:0] LAST_GRANT_RST = ID_W'(NUM_SRC - 1);

    arb_state_e         state_r, state_nxt_s;
    logic [ID_W-1:0]    grant_id_r, grant_id_nxt_s;
    logic [ID_W-1:0]    last_grant_r, last_grant_nxt_s;
    logic               busy_r, busy_nxt_s;
    logic               trunc_pulse_r, trunc_pulse_nxt_s;
    logic [CNT_W-1:0]   beat_cnt_r, beat_cnt_nxt_s;

    logic [ID_W-1:0]    pick_idx_s;
    logic               any_req_s;
    logic               src_last_s;
    logic               force_s;
    logic               accept_s;
    logic               sel_s;

    rr_priority_sel #(
        .NUM_SRC (NUM_SRC),
        .ID_W    (ID_W)
    ) u_rr_sel (
        .req     (s_axis_rvalid),
        .last    (last_grant_r),
        .gnt_idx (pick_idx_s),
        .any_req (any_req_s)
    );

    // Steer the granted requester onto the output stream while a packet is locked
    always_comb begin
        m_axis_rvalid = 1'b0;
        m_axis_rdata  = '0;
        src_last_s    = 1'b0;
        s_axis_rready = '0;
        sel_s         = 1'b0;
        for (int i = 0; i < NUM_SRC; i++) begin
            sel_s            = (state_r == LOCK) && (grant_id_r == ID_W'(i));
            s_axis_rready[i] = sel_s & m_axis_rready;
            m_axis_rvalid    = m_axis_rvalid | (sel_s & s_axis_rvalid[i]);
            src_last_s       = src_last_s | (sel_s & s_axis_rlast[i]);
            m_axis_rdata     = m_axis_rdata | ({DATA_W{sel_s}} & s_axis_rdata[i*DATA_W +: DATA_W]);
        end
        force_s       = (MAX_BEATS != 0) && (state_r == LOCK) && (beat_cnt_r == CNT_W'(CNT_LAST));
        m_axis_rlast  = src_last_s | force_s;
        accept_s      = m_axis_rvalid & m_axis_rready;
    end

    // Next-state logic: grant in IDLE, count beats and release on last in LOCK
    always_comb begin
        state_nxt_s       = state_r;
        grant_id_nxt_s    = grant_id_r;
        last_grant_nxt_s  = last_grant_r;
        busy_nxt_s        = busy_r;
        trunc_pulse_nxt_s = 1'b0;
        beat_cnt_nxt_s    = beat_cnt_r;
        case (state_r)
            IDLE: begin
                if (any_req_s) begin
                    grant_id_nxt_s = pick_idx_s;
                    busy_nxt_s     = 1'b1;
                    beat_cnt_nxt_s = '0;
                    state_nxt_s    = LOCK;
                end else begin
                    state_nxt_s    = IDLE;
                end
            end
            LOCK: begin
                if (accept_s && m_axis_rlast) begin
                    // Counter holds here, so it never passes MAX_BEATS-1
                    state_nxt_s       = IDLE;
                    busy_nxt_s        = 1'b0;
                    last_grant_nxt_s  = grant_id_r;
                    trunc_pulse_nxt_s = force_s & ~src_last_s;
                end else if (accept_s) begin
                    beat_cnt_nxt_s    = beat_cnt_r + CNT_W'(1);
                end else begin
                    state_nxt_s       = LOCK;
                end
            end
            default: begin
                state_nxt_s = IDLE;
                busy_nxt_s  = 1'b0;
            end
        endcase
    end

    // State and control registers with synchronous active-low reset
    always_ff @(posedge axi_aclk) begin
        if (!axi_aresetn) begin
            state_r       <= IDLE;
            grant_id_r    <= '0;
            last_grant_r  <= LAST_GRANT_RST;
            busy_r        <= 1'b0;
            trunc_pulse_r <= 1'b0;
            beat_cnt_r    <= '0;
        end else begin
            state_r       <= state_nxt_s;
            grant_id_r    <= grant_id_nxt_s;
            last_grant_r  <= last_grant_nxt_s;
            busy_r        <= busy_nxt_s;
            trunc_pulse_r <= trunc_pulse_nxt_s;
            beat_cnt_r    <= beat_cnt_nxt_s;
        end
    end

    assign grant_id    = grant_id_r;
    assign busy        = busy_r;
    assign trunc_pulse = trunc_pulse_r;

endmodule

// File: tb/tb_spi_send_arbiter.sv
// Self-checking bench for spi_send_arbiter: directed scenarios followed by
// randomized traffic, all checked against a packet-level reference model.
module tb_spi_send_arbiter;

    localparam int NSRC = 3;
    localparam int DW   = 8;
    localparam int MAXB = 4;
    localparam int IDW  = 2;

    logic                 clk;
    logic                 rstn;
    logic [NSRC-1:0]      s_v, s_r, s_l;
    logic [NSRC*DW-1:0]   s_d;
    logic                 m_v, m_r, m_l;
    logic [DW-1:0]        m_d;
    logic [IDW-1:0]       gid;
    logic                 busy, trunc;

    spi_send_arbiter #(
        .NUM_SRC   (NSRC),
        .DATA_W    (DW),
        .MAX_BEATS (MAXB),
        .ID_W      (IDW)
    ) dut (
        .axi_aclk      (clk),
        .axi_aresetn   (rstn),
        .s_axis_rvalid (s_v),
        .s_axis_rready (s_r),
        .s_axis_rdata  (s_d),
        .s_axis_rlast  (s_l),
        .m_axis_rvalid (m_v),
        .m_axis_rready (m_r),
        .m_axis_rdata  (m_d),
        .m_axis_rlast  (m_l),
        .grant_id      (gid),
        .busy          (busy),
        .trunc_pulse   (trunc)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Per-requester packet storage: {last, data}
    logic [8:0] mem [NSRC][1024];
    int         head [NSRC];
    int         tail [NSRC];
    logic       gap  [NSRC];
    logic       rdy;

    // Reference model: owner = -1 means nobody holds the link
    int         own;
    int         lastg;
    int         nbeat;
    logic       exp_busy;
    int         exp_gid;
    logic       exp_trunc;
    int         trunc_seen;
    logic [7:0] olog [$];

    int n_vec;
    int n_err;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_vec++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic push(input int s, input logic [7:0] d, input logic l);
        mem[s][tail[s]] = {l, d};
        tail[s]++;
    endtask

    task automatic drive();
        for (int i = 0; i < NSRC; i++) begin
            if (head[i] < tail[i]) begin
                s_v[i]          = ~gap[i];
                s_d[i*DW +: DW] = mem[i][head[i]][7:0];
                s_l[i]          = mem[i][head[i]][8];
            end else begin
                s_v[i]          = 1'b0;
                s_d[i*DW +: DW] = 8'h00;
                s_l[i]          = 1'b0;
            end
        end
        m_r = rdy;
    endtask

    // One clock: drive, compare against model, advance model, cross the edge
    task automatic step();
        logic       ev, el, acc;
        logic [7:0] ed;
        logic [2:0] er;
        int         pick;
        drive();
        #1;
        if (own >= 0) begin
            ev = s_v[own];
            ed = s_d[own*DW +: DW];
            el = s_l[own] | (nbeat == MAXB - 1);
            er = 3'(rdy) << own;
        end else begin
            ev = 1'b0;
            ed = 8'h00;
            el = 1'b0;
            er = 3'b000;
        end
        chk("m_valid", 32'(m_v), 32'(ev));
        chk("s_ready", 32'(s_r), 32'(er));
        chk("busy", 32'(busy), 32'(exp_busy));
        chk("grant_id", 32'(gid), 32'(exp_gid));
        chk("trunc_pulse", 32'(trunc), 32'(exp_trunc));
        if (own >= 0) begin
            chk("m_data", 32'(m_d), 32'(ed));
            chk("m_last", 32'(m_l), 32'(el));
        end
        acc = ev & rdy;
        if (!rstn) begin
            own = -1; lastg = NSRC - 1; nbeat = 0;
            exp_busy = 1'b0; exp_gid = 0; exp_trunc = 1'b0;
        end else begin
            exp_trunc = 1'b0;
            if (own < 0) begin
                pick = -1;
                for (int k = 1; k <= NSRC; k++) begin
                    if (pick < 0 && s_v[(lastg + k) % NSRC]) pick = (lastg + k) % NSRC;
                end
                if (pick >= 0) begin
                    own = pick; exp_busy = 1'b1; exp_gid = pick; nbeat = 0;
                end
            end else if (acc) begin
                olog.push_back(ed);
                if (el) begin
                    if (!s_l[own]) begin
                        exp_trunc = 1'b1;
                        trunc_seen++;
                    end
                    head[own]++;
                    lastg = own; own = -1; exp_busy = 1'b0;
                end else begin
                    head[own]++;
                    nbeat++;
                end
            end
        end
        @(posedge clk);
        #1;
    endtask

    function automatic bit all_done();
        bit d;
        d = (own < 0);
        for (int i = 0; i < NSRC; i++) if (head[i] < tail[i]) d = 1'b0;
        return d;
    endfunction

    task automatic drain();
        int cyc;
        for (int i = 0; i < NSRC; i++) gap[i] = 1'b0;
        cyc = 0;
        while (!all_done() && cyc < 500) begin
            step();
            cyc++;
        end
        chk("drain_done", 32'(all_done()), 32'd1);
        step();
    endtask

    task automatic do_reset();
        rstn = 1'b0;
        step();
        rstn = 1'b1;
    endtask

    initial begin
        int base, t0, cyc;
        n_vec = 0; n_err = 0; trunc_seen = 0;
        own = -1; lastg = NSRC - 1; nbeat = 0;
        exp_busy = 1'b0; exp_gid = 0; exp_trunc = 1'b0;
        rdy = 1'b1;
        for (int i = 0; i < NSRC; i++) begin
            head[i] = 0; tail[i] = 0; gap[i] = 1'b0;
        end
        rstn = 1'b0;
        drive();
        @(posedge clk);
        #1;
        do_reset();
        step();
        chk("rst_busy", 32'(busy), 32'd0);
        chk("rst_gid", 32'(gid), 32'd0);
        chk("rst_mvalid", 32'(m_v), 32'd0);

        // 1: single-beat packet from requester 1
        base = olog.size();
        push(1, 8'h5A, 1'b1);
        drain();
        chk("t1_size", 32'(olog.size() - base), 32'd1);
        chk("t1_data", 32'(olog[base]), 32'h5A);

        // 2: three 2-beat packets, served 0,1,2 after reset
        do_reset();
        base = olog.size();
        push(0, 8'hA0, 1'b0); push(0, 8'hA1, 1'b1);
        push(1, 8'hB0, 1'b0); push(1, 8'hB1, 1'b1);
        push(2, 8'hC0, 1'b0); push(2, 8'hC1, 1'b1);
        drain();
        chk("t2_size", 32'(olog.size() - base), 32'd6);
        chk("t2_b0", 32'(olog[base + 0]), 32'hA0);
        chk("t2_b1", 32'(olog[base + 1]), 32'hA1);
        chk("t2_b2", 32'(olog[base + 2]), 32'hB0);
        chk("t2_b3", 32'(olog[base + 3]), 32'hB1);
        chk("t2_b4", 32'(olog[base + 4]), 32'hC0);
        chk("t2_b5", 32'(olog[base + 5]), 32'hC1);

        // 3: backpressure on requester 0 while requester 2 waits
        base = olog.size();
        push(0, 8'hD0, 1'b0); push(0, 8'hD1, 1'b0); push(0, 8'hD2, 1'b1);
        push(2, 8'hE0, 1'b1);
        cyc = 0;
        while (!all_done() && cyc < 100) begin
            rdy = cyc[0] ? 1'b0 : 1'b1;
            step();
            cyc++;
        end
        rdy = 1'b1;
        drain();
        chk("t3_size", 32'(olog.size() - base), 32'd4);
        chk("t3_b0", 32'(olog[base + 0]), 32'hD0);
        chk("t3_b2", 32'(olog[base + 2]), 32'hD2);
        chk("t3_b3", 32'(olog[base + 3]), 32'hE0);

        // 4: beat limit truncates a long packet after 4 beats
        base = olog.size();
        t0 = trunc_seen;
        for (int j = 0; j < 6; j++) push(1, 8'(8'hF0 + j), (j == 5) ? 1'b1 : 1'b0);
        drain();
        chk("t4_trunc_count", 32'(trunc_seen - t0), 32'd1);
        chk("t4_size", 32'(olog.size() - base), 32'd6);
        chk("t4_b5", 32'(olog[base + 5]), 32'hF5);

        // 5: reset in the middle of a 4-beat packet
        base = olog.size();
        for (int j = 0; j < 4; j++) push(0, 8'(8'h60 + j), (j == 3) ? 1'b1 : 1'b0);
        cyc = 0;
        while (olog.size() < base + 1 && cyc < 20) begin
            step();
            cyc++;
        end
        chk("t5_one_beat", 32'(olog.size() - base), 32'd1);
        do_reset();
        chk("t5_busy", 32'(busy), 32'd0);
        chk("t5_mvalid", 32'(m_v), 32'd0);
        chk("t5_sready", 32'(s_r), 32'd0);
        chk("t5_gid", 32'(gid), 32'd0);
        for (int i = 0; i < NSRC; i++) head[i] = tail[i];
        step();
        base = olog.size();
        push(2, 8'h72, 1'b1);
        push(0, 8'h70, 1'b1);
        drain();
        chk("t5_first", 32'(olog[base]), 32'h70);
        chk("t5_second", 32'(olog[base + 1]), 32'h72);

        // 6: granted requester 2 stalls while requester 0 waits
        base = olog.size();
        push(2, 8'h80, 1'b0); push(2, 8'h81, 1'b0); push(2, 8'h82, 1'b1);
        step();
        step();
        push(0, 8'h90, 1'b1);
        gap[2] = 1'b1;
        for (int j = 0; j < 5; j++) begin
            step();
            chk("t6_gid_held", 32'(gid), 32'd2);
        end
        drain();
        chk("t6_size", 32'(olog.size() - base), 32'd4);
        chk("t6_b2", 32'(olog[base + 2]), 32'h82);
        chk("t6_b3", 32'(olog[base + 3]), 32'h90);

        // Randomized traffic, gaps and backpressure
        for (int c = 0; c < 600; c++) begin
            if ($urandom_range(0, 7) == 0) begin
                int s, len;
                s   = $urandom_range(0, NSRC - 1);
                len = $urandom_range(1, 6);
                if (tail[s] + len < 1000) begin
                    for (int j = 0; j < len; j++) push(s, 8'($urandom), (j == len - 1) ? 1'b1 : 1'b0);
                end
            end
            for (int i = 0; i < NSRC; i++) gap[i] = ($urandom_range(0, 4) == 0);
            rdy = ($urandom_range(0, 3) != 0);
            step();
        end
        rdy = 1'b1;
        drain();

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
